// File: rtl/seg_scan_decoder.sv
// Seven-segment scan receiver: filters, decodes and frames HEX0..HEX5.
// Define ERR_COUNT_EN to build the saturating error counter.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CNT = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        seg_stb,
   input  logic [2:0]  seg_dig,
   input  logic [6:0]  seg_in,
   output logic [23:0] digits,
   output logic [5:0]  digit_ok,
   output logic [3:0]  operand_a,
   output logic [3:0]  operand_b,
   output logic [7:0]  result,
   output logic        frame_done,
   output logic        err,
   output logic [7:0]  err_count
);

   localparam logic [3:0] STABLE = 4'(STABLE_CNT);

   typedef enum logic {COLLECT, DONE} state_t;

   state_t     state_q;
   state_t     state_d;
   logic       pat_ok;
   logic [3:0] dec_val;
   logic       dig_legal;
   logic       live;
   logic       err_d;
   logic       latch;
   logic [5:0] acc;

   always_comb begin
      pat_ok  = 1'b1;
      dec_val = 4'h0;
      case (seg_in)
         7'h40: dec_val = 4'h0;
         7'h79: dec_val = 4'h1;
         7'h24: dec_val = 4'h2;
         7'h30: dec_val = 4'h3;
         7'h19: dec_val = 4'h4;
         7'h12: dec_val = 4'h5;
         7'h02: dec_val = 4'h6;
         7'h78: dec_val = 4'h7;
         7'h00: dec_val = 4'h8;
         7'h18: dec_val = 4'h9;
         7'h08: dec_val = 4'hA;
         7'h03: dec_val = 4'hB;
         7'h46: dec_val = 4'hC;
         7'h21: dec_val = 4'hD;
         7'h06: dec_val = 4'hE;
         7'h0E: dec_val = 4'hF;
         default: pat_ok = 1'b0;
      endcase
   end

   assign dig_legal = (seg_dig < 3'd6);
   assign live      = seg_stb & ~clear & dig_legal;
   assign err_d     = seg_stb & ~clear & (~dig_legal | ~pat_ok);

   for (genvar d = 0; d < 6; d++) begin : g_dig
      logic [6:0] last_pat;
      logic [3:0] match_cnt;
      logic [3:0] cnt_nxt;
      logic [3:0] nib;
      logic       sel;
      logic       same;

      assign sel  = live & (seg_dig == 3'(d));
      assign same = (seg_in == last_pat);

      always_comb begin
         cnt_nxt = 4'd1;
         if (same) begin
            cnt_nxt = (match_cnt == STABLE) ? STABLE
                                            : match_cnt + 4'd1;
         end
      end

      assign acc[d] = sel & pat_ok & (cnt_nxt == STABLE);

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            last_pat  <= '0;
            match_cnt <= '0;
            nib       <= '0;
         end else if (clear) begin
            match_cnt <= '0;
            nib       <= '0;
         end else if (sel) begin
            if (pat_ok) begin
               last_pat  <= seg_in;
               match_cnt <= cnt_nxt;
               if (acc[d]) nib <= dec_val;
            end else begin
               match_cnt <= '0;
            end
         end
      end

      assign digits[4*d +: 4] = nib;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         COLLECT: if (!clear && digit_ok == 6'h3F) state_d = DONE;
         DONE:    state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   assign latch      = (state_q == COLLECT) & (state_d == DONE);
   assign frame_done = (state_q == DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= COLLECT;
         digit_ok  <= '0;
         operand_a <= '0;
         operand_b <= '0;
         result    <= '0;
         err       <= 1'b0;
      end else begin
         state_q <= state_d;
         err     <= err_d;
         if (latch) begin
            operand_b <= digits[3:0];
            operand_a <= digits[11:8];
            result    <= digits[23:16];
         end
         // a strobe accepted during DONE survives the frame clear
         if (clear) begin
            digit_ok <= '0;
         end else begin
            digit_ok <= ((state_q == DONE) ? 6'h00 : digit_ok) | acc;
         end
      end
   end

`ifdef ERR_COUNT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if (clear) begin
         err_count <= '0;
      end else if (err_d && err_count != 8'hFF) begin
         err_count <= err_count + 8'd1;
      end
   end
`else
   assign err_count = 8'h00;
`endif

endmodule
